// File: rtl/req_rr_encoder_if.sv
// Request/grant bundle for req_rr_encoder.
//   slave  : the encoder side (receives requests, presents grants)
//   master : the requester/consumer side (drives requests and ready)
// Signals:
//   req_in       N      request lines, synchronous to clk
//   enable       1      capture and launch enable
//   ready_in     1      downstream accepts idx_out this cycle
//   idx_out      IDX_W  index of granted request
//   valid_out    1      idx_out valid
//   pending_out  N      registered pending-request vector
//   any_pending  1      |pending_out
//   overflow     1      one-cycle pulse: new edge hit an already-pending bit
interface req_rr_encoder_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = $clog2(N)
) ();

  logic [N-1:0]     req_in;
  logic             enable;
  logic             ready_in;
  logic [IDX_W-1:0] idx_out;
  logic             valid_out;
  logic [N-1:0]     pending_out;
  logic             any_pending;
  logic             overflow;

  modport slave (
    input  req_in,
    input  enable,
    input  ready_in,
    output idx_out,
    output valid_out,
    output pending_out,
    output any_pending,
    output overflow
  );

  modport master (
    output req_in,
    output enable,
    output ready_in,
    input  idx_out,
    input  valid_out,
    input  pending_out,
    input  any_pending,
    input  overflow
  );

endinterface

// File: rtl/req_rr_encoder.sv
// Request-capture stage in front of the 16-input OR/encoder block.
// Rising edges (or levels, EDGE_DET=0) on req_in are latched into a pending
// vector; pending bits are then granted one at a time in round-robin order
// over a valid/ready handshake, each grant presented as an encoded index.
// The state registers are written single-copy; triplication is applied to
// them afterwards by TMRG.
// Ports:
//   clk    in  clock, all logic on the rising edge
//   rst_n  in  asynchronous reset, active-low
//   bus    slave side of req_rr_encoder_if (requests, enable, ready in;
//          idx/valid, pending vector, any_pending, overflow out)
module req_rr_encoder #(
  parameter int unsigned N        = 16,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  req_rr_encoder_if.slave    bus
);

  // State
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     req_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;

  // Combinational helpers
  logic [N-1:0]     set_vec;
  logic [N-1:0]     grant_mask;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             slot_open;
  logic             launch;

  // Capture vector: new edges (or raw levels) this cycle.
  always_comb begin
    if (EDGE_DET) begin
      set_vec = bus.req_in & ~req_q;
    end else begin
      set_vec = bus.req_in;
    end
  end

  // Round-robin pick: first registered pending bit at or above ptr, wrapping
  // modulo N. Only the registered vector is scanned, so same-cycle edges are
  // never eligible for launch.
  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;
    sel     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = k + 32'(ptr_q);
      if (pos >= N) begin
        pos = pos - N;
      end
      pos_idx = IDX_W'(pos);
      if (!found && pending_q[pos_idx]) begin
        sel   = pos_idx;
        found = 1'b1;
      end
    end
  end

  // Slot is free when nothing is presented or the presented grant is taken.
  assign slot_open = !valid_q || bus.ready_in;
  assign launch    = slot_open && bus.enable && found;

  always_comb begin
    grant_mask = '0;
    if (launch) begin
      grant_mask = {{(N-1){1'b0}}, 1'b1} << sel;
    end
  end

  // Pending update: clear the granted bit first, then OR in captures so a
  // same-cycle edge on the granted bit keeps it pending.
  always_comb begin
    pending_d = pending_q & ~grant_mask;
    if (bus.enable) begin
      pending_d = pending_d | set_vec;
    end
  end

  // Overflow only when an edge lands on a bit that stays pending; the bit
  // being granted this cycle is excluded since the edge simply re-arms it.
  always_comb begin
    overflow_d = 1'b0;
    if (bus.enable) begin
      overflow_d = |(set_vec & pending_q & ~grant_mask);
    end
  end

  // Output register and pointer. While the slot is closed (backpressure)
  // everything holds. An open slot with nothing to launch drops valid but
  // leaves idx at its last value.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (slot_open) begin
      if (launch) begin
        valid_d = 1'b1;
        idx_d   = sel;
        if (sel == IDX_W'(N - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = sel + 1'b1;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      req_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      req_q      <= bus.req_in;  // tracks req_in even while disabled
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.idx_out     = idx_q;
  assign bus.valid_out   = valid_q;
  assign bus.pending_out = pending_q;
  assign bus.any_pending = |pending_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_req_rr_encoder.sv
module tb_req_rr_encoder;

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  logic clk;
  logic rst_n;

  req_rr_encoder_if #(.N(N), .IDX_W(IDX_W)) bus ();

  req_rr_encoder #(
    .N        (N),
    .IDX_W    (IDX_W),
    .EDGE_DET (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] exp_mon;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Grant monitor: a transfer happens at the next rising edge whenever
  // valid && ready are seen at the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.valid_out && bus.ready_in) begin
      if (exp_q.size() == 0) begin
        check("spurious_grant_q_size", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_mon = exp_q.pop_front();
        check("grant_idx", 32'(bus.idx_out), 32'(exp_mon));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      check("drain_timeout_q_size", 32'(exp_q.size()), 32'd0);
    end
    repeat (3) step();  // idle cycles so an extra grant would be flagged
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.req_in   = '0;
    bus.enable   = 1'b1;
    bus.ready_in = 1'b0;

    // 1. Reset: build up state, then clear it asynchronously mid-cycle.
    step();
    step();
    rst_n      = 1'b1;
    bus.req_in = 16'hFFFF;
    step();
    step();
    check("pre_reset_valid", 32'(bus.valid_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid",    32'(bus.valid_out),   32'd0);
    check("rst_idx",      32'(bus.idx_out),     32'd0);
    check("rst_pending",  32'(bus.pending_out), 32'd0);
    check("rst_any",      32'(bus.any_pending), 32'd0);
    check("rst_overflow", 32'(bus.overflow),    32'd0);
    bus.ready_in = 1'b1;
    step();
    rst_n = 1'b1;  // req_in still all ones: every bit is an edge at first clock
    for (int i = 0; i < 16; i++) exp_q.push_back(IDX_W'(i));
    step();
    check("release_pending", 32'(bus.pending_out), 32'hFFFF);
    check("release_valid",   32'(bus.valid_out),   32'd0);
    check("release_any",     32'(bus.any_pending), 32'd1);
    bus.req_in = '0;
    wait_drain(40);
    check("t1_pending_empty", 32'(bus.pending_out), 32'd0);

    // 2. Single request: grant appears two cycles after the rise, for one cycle.
    bus.req_in = 16'h0010;
    exp_q.push_back(4'd4);
    step();
    check("t2_pending",    32'(bus.pending_out), 32'h0010);
    check("t2_valid_early", 32'(bus.valid_out),  32'd0);
    step();
    check("t2_valid",      32'(bus.valid_out),   32'd1);
    check("t2_idx",        32'(bus.idx_out),     32'd4);
    check("t2_pending_clr", 32'(bus.pending_out), 32'd0);
    step();
    check("t2_valid_drop", 32'(bus.valid_out),   32'd0);
    bus.req_in = '0;
    wait_drain(10);

    // 3. Round robin from ptr=0, wrap, then starting at ptr=1.
    do_reset();
    bus.req_in = 16'h8001;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd15);
    step();
    bus.req_in = '0;
    wait_drain(10);
    bus.req_in = 16'h8001;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd15);
    step();
    bus.req_in = '0;
    wait_drain(10);
    bus.req_in = 16'h0001;
    exp_q.push_back(4'd0);
    step();
    bus.req_in = '0;
    wait_drain(10);
    bus.req_in = 16'h0003;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    step();
    bus.req_in = '0;
    wait_drain(10);

    // 4. Backpressure: grant 2 held while bit 7 is captured, then 7 follows.
    bus.ready_in = 1'b0;
    bus.req_in   = 16'h0004;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd7);
    step();
    step();
    check("t4_valid", 32'(bus.valid_out), 32'd1);
    check("t4_idx",   32'(bus.idx_out),   32'd2);
    bus.req_in = 16'h0084;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_idx",     32'(bus.idx_out),     32'd2);
      check("t4_hold_valid",   32'(bus.valid_out),   32'd1);
      check("t4_hold_pending", 32'(bus.pending_out), 32'h0080);
      step();
    end
    bus.ready_in = 1'b1;
    bus.req_in   = '0;
    wait_drain(10);

    // 5. Overflow: bit 3 re-pulsed while pending behind a stalled grant of 9.
    bus.ready_in = 1'b0;
    bus.req_in   = 16'h0200;
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd3);
    step();
    step();
    check("t5_idx9", 32'(bus.idx_out), 32'd9);
    bus.req_in = 16'h0008;
    step();
    check("t5_pending",     32'(bus.pending_out), 32'h0008);
    check("t5_no_overflow", 32'(bus.overflow),    32'd0);
    bus.req_in = '0;
    step();
    bus.req_in = 16'h0008;
    step();
    check("t5_overflow",     32'(bus.overflow),    32'd1);
    check("t5_pending_same", 32'(bus.pending_out), 32'h0008);
    bus.req_in = '0;
    step();
    check("t5_overflow_end", 32'(bus.overflow), 32'd0);
    bus.ready_in = 1'b1;
    wait_drain(10);

    // 6. Mid-operation reset with a grant presented and 0xF0 pending.
    bus.ready_in = 1'b0;
    bus.req_in   = 16'h0001;
    step();
    step();
    bus.req_in = 16'h00F1;
    step();
    check("t6_valid",   32'(bus.valid_out),   32'd1);
    check("t6_pending", 32'(bus.pending_out), 32'h00F0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",   32'(bus.valid_out),   32'd0);
    check("t6_rst_pending", 32'(bus.pending_out), 32'd0);
    check("t6_rst_any",     32'(bus.any_pending), 32'd0);
    bus.req_in   = '0;
    bus.ready_in = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_stale_valid", 32'(bus.valid_out), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
